// File: rtl/openram_bist_pkg.sv
// Shared types and constants for the March C- BIST sequencer of the OpenRAM 1RW1R macro.
package openram_bist_pkg;

   typedef enum logic [2:0] {
      M0 = 3'd0,
      M1 = 3'd1,
      M2 = 3'd2,
      M3 = 3'd3,
      M4 = 3'd4,
      M5 = 3'd5
   } elem_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic [7:0] BG_BYTE_0 = 8'h00;
   localparam logic [7:0] BG_BYTE_1 = 8'h55;
   localparam logic [7:0] BG_BYTE_2 = 8'h33;
   localparam logic [7:0] BG_BYTE_3 = 8'h0F;

   localparam int unsigned TOTAL_OPS = 2560;
   localparam logic [15:0] ERR_MAX   = 16'hFFFF;

   // Background byte, replicated across the word by the user.
   function automatic logic [7:0] bg_byte(input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = BG_BYTE_0;
         2'd1:    b = BG_BYTE_1;
         2'd2:    b = BG_BYTE_2;
         default: b = BG_BYTE_3;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter for the March sequencer; last_o flags the final address
// of the current sweep direction.
module bist_addr_gen #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic              load_down_i,
   input  logic              step_i,
   input  logic              down_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [ADDR_W-1:0] addr_nxt_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;

   always_comb begin
      addr_d = addr_q;
      if (clr_i) begin
         addr_d = '0;
      end else if (load_i) begin
         addr_d = load_down_i ? '1 : '0;
      end else if (step_i) begin
         addr_d = down_i ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) addr_q <= '0;
      else     addr_q <= addr_d;
   end

   assign addr_o     = addr_q;
   assign addr_nxt_o = addr_d;
   assign last_o     = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer driving both ports of a 1RW1R OpenRAM macro.
// Define SRAM_BIST_RO_CHECK_EN to also read and check every word through port1.
module sram_march_bist
   import openram_bist_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_WMASK = 4
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [1:0]           pat_sel,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ADDR_W-1:0]    fail_addr,
   output logic [2:0]           fail_elem,
   output logic [15:0]          err_count,
   output logic                 csb0,
   output logic                 web0,
   output logic [NUM_WMASK-1:0] wmask0,
   output logic [ADDR_W-1:0]    addr0,
   output logic [DATA_W-1:0]    din0,
   input  logic [DATA_W-1:0]    dout0,
   output logic                 csb1,
   output logic [ADDR_W-1:0]    addr1,
   input  logic [DATA_W-1:0]    dout1
);

`ifdef SRAM_BIST_RO_CHECK_EN
   localparam bit RO_EN = 1'b1;
`else
   localparam bit RO_EN = 1'b0;
`endif

   state_e state_q, state_d;
   elem_e  elem_q, elem_d, cmp_elem_q, cmp_elem_d;
   op_e    op_q, op_d;

   logic [DATA_W-1:0]    bg_q, bg_d, exp_q, exp_d, din0_q, din0_d;
   logic [ADDR_W-1:0]    cmp_addr_q, cmp_addr_d, fail_addr_q, fail_addr_d, addr1_q, addr1_d;
   logic [2:0]           fail_elem_q, fail_elem_d;
   logic [15:0]          err_q, err_d;
   logic [NUM_WMASK-1:0] wmask0_q, wmask0_d;
   logic rd_vld_q, rd_vld_d, pass_q, pass_d, done_q, done_d, busy_q, busy_d;
   logic csb0_q, csb0_d, web0_q, web0_d, csb1_q, csb1_d;
   logic mism, run_d, wr_d;

   logic              ag_clr, ag_load, ag_load_down, ag_step, ag_down, ag_last;
   logic [ADDR_W-1:0] ag_addr, ag_addr_nxt;

   // Even elements read ~B and write B; odd elements the reverse.
   function automatic logic [DATA_W-1:0] op_data(input elem_e e, input op_e o,
                                                  input logic [DATA_W-1:0] b);
      logic inv;
      inv = (o == OP_RD) ? ~e[0] : e[0];
      return inv ? ~b : b;
   endfunction

   assign ag_down = (elem_q >= M3);

   bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk_in      (clk_in),
      .rst         (rst),
      .clr_i       (ag_clr),
      .load_i      (ag_load),
      .load_down_i (ag_load_down),
      .step_i      (ag_step),
      .down_i      (ag_down),
      .addr_o      (ag_addr),
      .addr_nxt_o  (ag_addr_nxt),
      .last_o      (ag_last)
   );

   always_comb begin
      state_d      = state_q;
      elem_d       = elem_q;
      op_d         = op_q;
      bg_d         = bg_q;
      exp_d        = exp_q;
      rd_vld_d     = 1'b0;
      cmp_addr_d   = cmp_addr_q;
      cmp_elem_d   = cmp_elem_q;
      err_d        = err_q;
      fail_addr_d  = fail_addr_q;
      fail_elem_d  = fail_elem_q;
      pass_d       = pass_q;
      done_d       = 1'b0;
      ag_clr       = 1'b0;
      ag_load      = 1'b0;
      ag_load_down = 1'b0;
      ag_step      = 1'b0;
      mism         = 1'b0;

      // Compare the read issued last cycle; an abort throws it away.
      if (state_q != ST_IDLE && !abort && rd_vld_q) begin
         mism = (dout0 != exp_q) || (RO_EN && (dout1 != exp_q));
      end
      if (mism) begin
         if (err_q == '0) begin
            fail_addr_d = cmp_addr_q;
            fail_elem_d = 3'(cmp_elem_q);
         end
         if (err_q != ERR_MAX) err_d = err_q + 16'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d     = ST_RUN;
               bg_d        = {(DATA_W/8){bg_byte(pat_sel)}};
               elem_d      = M0;
               op_d        = OP_WR;
               ag_clr      = 1'b1;
               err_d       = '0;
               fail_addr_d = '0;
               fail_elem_d = '0;
               pass_d      = 1'b0;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               ag_clr  = 1'b1;
               pass_d  = 1'b0;
            end else begin
               rd_vld_d   = (op_q == OP_RD);
               exp_d      = op_data(elem_q, op_q, bg_q);
               cmp_addr_d = ag_addr;
               cmp_elem_d = elem_q;
               if (op_q == OP_RD && elem_q != M0 && elem_q != M5) begin
                  op_d = OP_WR;
               end else if (ag_last) begin
                  if (elem_q == M5) begin
                     state_d = ST_DRAIN;
                     ag_clr  = 1'b1;
                  end else begin
                     elem_d       = elem_e'(elem_q + 3'd1);
                     op_d         = OP_RD;
                     ag_load      = 1'b1;
                     ag_load_down = (elem_q >= M2);
                  end
               end else begin
                  ag_step = 1'b1;
                  op_d    = (elem_q == M0) ? OP_WR : OP_RD;
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_IDLE;
            if (abort) begin
               pass_d = 1'b0;
            end else begin
               done_d = 1'b1;
               pass_d = (err_d == '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Port registers carry the op selected for the next cycle.
      run_d    = (state_d == ST_RUN);
      wr_d     = run_d && (op_d == OP_WR);
      busy_d   = (state_d != ST_IDLE);
      csb0_d   = ~run_d;
      web0_d   = ~wr_d;
      wmask0_d = wr_d ? '1 : '0;
      din0_d   = wr_d ? op_data(elem_d, op_d, bg_d) : '0;
      csb1_d   = ~(RO_EN && run_d && (op_d == OP_RD));
      addr1_d  = csb1_d ? '0 : ag_addr_nxt;
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         elem_q      <= M0;
         op_q        <= OP_WR;
         bg_q        <= '0;
         exp_q       <= '0;
         rd_vld_q    <= 1'b0;
         cmp_addr_q  <= '0;
         cmp_elem_q  <= M0;
         err_q       <= '0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         pass_q      <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         csb0_q      <= 1'b1;
         web0_q      <= 1'b1;
         wmask0_q    <= '0;
         din0_q      <= '0;
         csb1_q      <= 1'b1;
         addr1_q     <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         op_q        <= op_d;
         bg_q        <= bg_d;
         exp_q       <= exp_d;
         rd_vld_q    <= rd_vld_d;
         cmp_addr_q  <= cmp_addr_d;
         cmp_elem_q  <= cmp_elem_d;
         err_q       <= err_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
         pass_q      <= pass_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         csb0_q      <= csb0_d;
         web0_q      <= web0_d;
         wmask0_q    <= wmask0_d;
         din0_q      <= din0_d;
         csb1_q      <= csb1_d;
         addr1_q     <= addr1_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_addr = fail_addr_q;
   assign fail_elem = fail_elem_q;
   assign err_count = err_q;
   assign csb0      = csb0_q;
   assign web0      = web0_q;
   assign wmask0    = wmask0_q;
   assign addr0     = ag_addr;
   assign din0      = din0_q;
   assign csb1      = csb1_q;
   assign addr1     = addr1_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural 1RW1R SRAM with injectable read faults,
// table of full March runs plus abort / restart / reset corner sequences.
module tb_sram_march_bist;

   logic        clk_in = 1'b0;
   logic        rst, start, abort;
   logic [1:0]  pat_sel;
   logic        busy, done, pass;
   logic [7:0]  fail_addr;
   logic [2:0]  fail_elem;
   logic [15:0] err_count;
   logic        csb0, web0, csb1;
   logic [3:0]  wmask0;
   logic [7:0]  addr0, addr1;
   logic [31:0] din0, dout0, dout1;

   int checks   = 0;
   int failures = 0;
   int fault    = 0;

   logic [31:0] mem [256];

   always #5 clk_in = ~clk_in;

   sram_march_bist dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .pat_sel   (pat_sel),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem),
      .err_count (err_count),
      .csb0      (csb0),
      .web0      (web0),
      .wmask0    (wmask0),
      .addr0     (addr0),
      .din0      (din0),
      .dout0     (dout0),
      .csb1      (csb1),
      .addr1     (addr1),
      .dout1     (dout1)
   );

   // Fault 1: port0 bit0 stuck-1 @2A; 2: port0 all stuck-0 @00; 3: port1 bit31 stuck-0 @FF.
   function automatic logic [31:0] rd_port0(input logic [31:0] d, input logic [7:0] a);
      logic [31:0] r;
      r = d;
      if (fault == 1 && a == 8'h2A) r[0] = 1'b1;
      if (fault == 2 && a == 8'h00) r = 32'h0;
      return r;
   endfunction

   function automatic logic [31:0] rd_port1(input logic [31:0] d, input logic [7:0] a);
      logic [31:0] r;
      r = d;
      if (fault == 3 && a == 8'hFF) r[31] = 1'b0;
      return r;
   endfunction

   always @(posedge clk_in) begin
      if (!csb0 && !web0) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
         end
      end
      if (!csb0 && web0) dout0 <= rd_port0(mem[addr0], addr0);
      if (!csb1)         dout1 <= rd_port1(mem[addr1], addr1);
   end

   function automatic logic [31:0] bg_pat(input logic [1:0] ps);
      case (ps)
         2'd0:    return 32'h0000_0000;
         2'd1:    return 32'h5555_5555;
         2'd2:    return 32'h3333_3333;
         default: return 32'h0F0F_0F0F;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Caller sits #1 after a posedge. Cycle n counts edges after the start-sampling edge.
   task automatic run_bist(input logic [1:0] ps, input bit spam, input int abort_at,
                           output int done_cyc, output int ndone, output int nbusy);
      done_cyc = -1;
      ndone    = 0;
      nbusy    = 0;
      pat_sel  = ps;
      start    = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0;
      for (int n = 1; n <= 2600; n++) begin
         if (n == 1) begin
            chk("c1_busy", 32'(busy), 32'd1);
            chk("c1_csb0", 32'(csb0), 32'd0);
            chk("c1_web0", 32'(web0), 32'd0);
            chk("c1_wmask0", 32'(wmask0), 32'hF);
            chk("c1_addr0", 32'(addr0), 32'd0);
            chk("c1_din0", din0, bg_pat(ps));
            chk("c1_err_cleared", 32'(err_count), 32'd0);
            chk("c1_pass_cleared", 32'(pass), 32'd0);
            chk("c1_fail_addr_cleared", 32'(fail_addr), 32'd0);
            chk("c1_fail_elem_cleared", 32'(fail_elem), 32'd0);
         end
         if (n == 257) begin
            chk("m1_first_read_web0", 32'(web0), 32'd1);
            chk("m1_first_read_addr0", 32'(addr0), 32'd0);
            chk("m1_first_read_addr1", 32'(addr1), 32'd0);
`ifdef SRAM_BIST_RO_CHECK_EN
            chk("m1_first_read_csb1", 32'(csb1), 32'd0);
`else
            chk("m1_first_read_csb1", 32'(csb1), 32'd1);
`endif
         end
         if (abort_at > 0 && n == abort_at + 1) begin
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_csb0", 32'(csb0), 32'd1);
            chk("abort_pass", 32'(pass), 32'd0);
         end
         if (done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = n;
         end
         if (busy) nbusy++;
         abort = (abort_at > 0 && n == abort_at);
         start = spam && (n < 2400) && (n % 101 == 0);
         @(posedge clk_in); #1;
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   typedef struct {
      logic [1:0] ps;
      int         flt;
      logic       exp_pass;
      int         exp_err;
      logic [7:0] exp_addr;
      logic [2:0] exp_elem;
   } vec_t;

   vec_t vecs[6];
   int   dc, nd, nb, cnt;

   initial begin
      vecs[0] = '{2'd0, 0, 1'b1, 0, 8'h00, 3'd0};
      vecs[1] = '{2'd1, 1, 1'b0, 2, 8'h2A, 3'd2};
      vecs[2] = '{2'd0, 2, 1'b0, 2, 8'h00, 3'd2};
      vecs[3] = '{2'd2, 2, 1'b0, 5, 8'h00, 3'd1};
      vecs[4] = '{2'd3, 1, 1'b0, 2, 8'h2A, 3'd2};
`ifdef SRAM_BIST_RO_CHECK_EN
      vecs[5] = '{2'd0, 3, 1'b0, 2, 8'hFF, 3'd2};
`else
      vecs[5] = '{2'd0, 3, 1'b1, 0, 8'h00, 3'd0};
`endif

      rst = 1'b1; start = 1'b0; abort = 1'b0; pat_sel = 2'd0;
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_fail_addr", 32'(fail_addr), 32'd0);
      chk("rst_fail_elem", 32'(fail_elem), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_csb0", 32'(csb0), 32'd1);
      chk("rst_web0", 32'(web0), 32'd1);
      chk("rst_csb1", 32'(csb1), 32'd1);
      chk("rst_wmask0", 32'(wmask0), 32'd0);
      chk("rst_addr0", 32'(addr0), 32'd0);
      chk("rst_addr1", 32'(addr1), 32'd0);
      chk("rst_din0", din0, 32'd0);
      rst = 1'b0;
      @(posedge clk_in); #1;

      for (int i = 0; i < 6; i++) begin
         fault = vecs[i].flt;
         run_bist(vecs[i].ps, 1'b0, 0, dc, nd, nb);
         chk($sformatf("v%0d_done_cycle", i), 32'(dc), 32'd2562);
         chk($sformatf("v%0d_done_count", i), 32'(nd), 32'd1);
         chk($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'd2561);
         chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
         chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d_fail_addr", i), 32'(fail_addr), 32'(vecs[i].exp_addr));
         chk($sformatf("v%0d_fail_elem", i), 32'(fail_elem), 32'(vecs[i].exp_elem));
      end

      // Abort mid-run, then a clean full run.
      fault = 0;
      run_bist(2'd0, 1'b0, 500, dc, nd, nb);
      chk("abort_no_done", 32'(nd), 32'd0);
      chk("abort_busy_cycles", 32'(nb), 32'd500);
      run_bist(2'd2, 1'b0, 0, dc, nd, nb);
      chk("after_abort_done_cycle", 32'(dc), 32'd2562);
      chk("after_abort_pass", 32'(pass), 32'd1);

      // Repeated start pulses while busy.
      run_bist(2'd1, 1'b1, 0, dc, nd, nb);
      chk("spam_done_cycle", 32'(dc), 32'd2562);
      chk("spam_done_count", 32'(nd), 32'd1);
      chk("spam_busy_cycles", 32'(nb), 32'd2561);
      chk("spam_pass", 32'(pass), 32'd1);

      // start and abort together in IDLE: abort wins.
      start = 1'b1; abort = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0; abort = 1'b0;
      cnt = 0;
      for (int n = 0; n < 5; n++) begin
         if (busy || !csb0) cnt++;
         @(posedge clk_in); #1;
      end
      chk("start_abort_idle_busy", 32'(cnt), 32'd0);

      // Synchronous reset mid-run.
      fault = 1;
      pat_sel = 2'd1;
      start = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0;
      repeat (600) @(posedge clk_in);
      #1;
      chk("midrun_err_before_rst", 32'(err_count), 32'd0);
      chk("midrun_busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk_in); #1;
      rst = 1'b0;
      chk("midrun_rst_busy", 32'(busy), 32'd0);
      chk("midrun_rst_csb0", 32'(csb0), 32'd1);
      chk("midrun_rst_addr0", 32'(addr0), 32'd0);
      chk("midrun_rst_pass", 32'(pass), 32'd0);
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
         if (done || busy) cnt++;
         @(posedge clk_in); #1;
      end
      chk("midrun_rst_quiet", 32'(cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
